// File: rtl/pg_serial_resolve.sv
`default_nettype none
// ============================================================================
// Module      : pg_serial_resolve
// Description : Bit-serial resolver that turns LSB-first (gen, prop) beats
//               into sum bits, carry-out and group generate/propagate flags.
// Revision    : 1.0 - initial release
// ============================================================================
module pg_serial_resolve #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             c_in,
    input  logic             in_valid,
    input  logic             in_gen,
    input  logic             in_prop,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             grp_gen,
    output logic             grp_prop,
    output logic             pg_err
);

    localparam int c_idx_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_carry_nxt;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_carry;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_c_out;
    logic                 r_grp_gen;
    logic                 r_grp_prop;
    logic                 r_pg_err;

    assign w_last      = (r_idx == c_last_idx);
    assign w_carry_nxt = in_gen | (in_prop & r_carry);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Handshake outputs are forced low while rst_n is asserted.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                in_ready = rst_n;
                w_accept = in_valid;
                if (in_valid && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = rst_n;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_sum      <= '0;
            r_c_out    <= 1'b0;
            r_grp_gen  <= 1'b0;
            r_grp_prop <= 1'b1;
            r_pg_err   <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_idx      <= '0;
                r_carry    <= c_in;
                r_sum      <= '0;
                r_grp_gen  <= 1'b0;
                r_grp_prop <= 1'b1;
                r_pg_err   <= 1'b0;
            end
        end else if (w_accept) begin
            r_sum[r_idx] <= in_prop ^ r_carry;
            r_carry      <= w_carry_nxt;
            r_grp_gen    <= in_gen | (in_prop & r_grp_gen);
            r_grp_prop   <= r_grp_prop & in_prop;
            r_pg_err     <= r_pg_err | (in_gen & in_prop);
            // Index parks on the last position rather than wrapping.
            if (w_last) begin
                r_c_out <= w_carry_nxt;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign sum      = r_sum;
    assign c_out    = r_c_out;
    assign grp_gen  = r_grp_gen;
    assign grp_prop = r_grp_prop;
    assign pg_err   = r_pg_err;

endmodule
`default_nettype wire

// File: doc/pg_serial_resolve.md
PG_SERIAL_RESOLVE -- requirements
Module: pg_serial_resolve

Interface
REQ-001 Parameter: WIDTH, default 8, number of bit positions per operand (legal 2..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  begin a new operation; sampled only in IDLE.
REQ-005 c_in  input  1  carry-in for bit 0; captured on the cycle start is accepted.
REQ-006 in_valid  input  1  a (gen, prop) beat is present.
REQ-007 in_gen  input  1  bit generate, x AND y.
REQ-008 in_prop  input  1  bit propagate, x XOR y.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 out_valid  output  1  result registers hold a completed operation.
REQ-011 out_ready  input  1  downstream consumes the result.
REQ-012 sum  output  WIDTH  resolved sum bits, bit i from beat i.
REQ-013 c_out  output  1  carry out of bit WIDTH-1.
REQ-014 grp_gen  output  1  group generate over all WIDTH bits (c_in excluded).
REQ-015 grp_prop  output  1  group propagate, AND of all prop bits.
REQ-016 pg_err  output  1  sticky: some beat of this operation had in_gen=in_prop=1.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, COLLECT and DONE.
REQ-018 IDLE: in_ready=0; start=1 -> COLLECT next cycle, carry<=c_in, index<=0, grp_gen<=0, grp_prop<=1, pg_err<=0, sum<=0.
REQ-019 COLLECT: in_ready=1; a beat is accepted when in_valid AND in_ready; no acceptance -> all state holds.
REQ-020 On an accepted beat at index i: sum[i]<=in_prop XOR carry; carry<=in_gen OR (in_prop AND carry).
REQ-021 On an accepted beat: grp_gen<=in_gen OR (in_prop AND grp_gen); grp_prop<=grp_prop AND in_prop; pg_err<=pg_err OR (in_gen AND in_prop).
REQ-022 Beats are LSB first; index increments by 1 per accepted beat, with no wrap inside an operation.
REQ-023 Accepted beat with index=WIDTH-1 -> DONE next cycle; c_out<=resulting carry.
REQ-024 DONE: out_valid=1, in_ready=0; sum, c_out, grp_gen, grp_prop and pg_err stable until handoff.
REQ-025 DONE with out_ready=1 -> IDLE next cycle; out_valid falls that cycle; result registers keep their last values.
REQ-026 start is ignored outside IDLE; start held high across DONE->IDLE begins a new operation on the first IDLE cycle.
REQ-027 Latency: start cycle + WIDTH accepted beats + 1 -> out_valid; minimum WIDTH+1 cycles after start accepted.
REQ-028 pg_err does not alter the arithmetic; sum and carry follow REQ-020 exactly.
REQ-029 Invariant in DONE: c_out = grp_gen OR (grp_prop AND captured c_in).

Reset
REQ-030 rst_n=0 at a rising edge -> state IDLE, index 0, carry 0, sum 0, c_out 0, grp_gen 0, grp_prop 1, pg_err 0.
REQ-031 In reset: out_valid=0 and in_ready=0; reset takes priority over start, beats and out_ready.
REQ-032 Reset in COLLECT or DONE aborts the operation; there is no partial result and no out_valid pulse.
REQ-033 After rst_n returns high, the first start is honoured on the following edge.

Verification
REQ-034 WIDTH=8, c_in=0, x=0x5A, y=0x33 as 8 back-to-back beats -> sum=0x8D, c_out=0, grp_gen=0, grp_prop=0, pg_err=0.
REQ-035 WIDTH=8, c_in=1, all prop=1, gen=0 -> sum=0x00, c_out=1, grp_prop=1, grp_gen=0; out_valid exactly 9 cycles after start.
REQ-036 in_valid toggled 1/0 every cycle, x=0xFF, y=0x01, c_in=0 -> sum=0x00, c_out=1, grp_gen=1; result stalls correctly.
REQ-037 out_ready held 0 for 5 cycles in DONE -> outputs unchanged; start pulses during DONE are ignored; handoff on out_ready=1.
REQ-038 Beat 3 has gen=prop=1 -> pg_err=1 in DONE; the next operation with clean beats -> pg_err=0.
REQ-039 rst_n=0 after 4 accepted beats -> next cycle IDLE, out_valid=0, sum=0; a fresh operation completes correctly.
